// File: rtl/lvl_states_bram_arbiter.sv
// Round-robin owner arbiter for the single port of the lvls-states BRAM.
// Muxes the owner's access onto the port, tracks reads, and flags accesses from non-owners.
module lvl_states_bram_arbiter #(
  parameter int N_REQ                  = 4,
  parameter int WIDTH_LVL_STATES       = 30,
  parameter int ADDR_WIDTH_LVLS_STATES = 9,
  parameter int RD_LATENCY             = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_REQ-1:0]                          req_i,
  output logic [N_REQ-1:0]                          grant_o,
  input  logic [N_REQ-1:0]                          req_we_i,
  input  logic [N_REQ*ADDR_WIDTH_LVLS_STATES-1:0]   req_addr_i,
  input  logic [N_REQ*WIDTH_LVL_STATES-1:0]         req_data_i,
  input  logic [N_REQ-1:0]                          req_rd_i,
  output logic [WIDTH_LVL_STATES-1:0]               rd_data_o,
  output logic [N_REQ-1:0]                          rd_valid_o,
  output logic                                      ram_we_o,
  output logic [ADDR_WIDTH_LVLS_STATES-1:0]         ram_addr_o,
  output logic [WIDTH_LVL_STATES-1:0]               ram_data_o,
  input  logic [WIDTH_LVL_STATES-1:0]               ram_data_i,
  output logic                                      err_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW    = ADDR_WIDTH_LVLS_STATES;
  localparam int DW    = WIDTH_LVL_STATES;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   pick, cand;
  logic               pick_found;
  logic [N_REQ-1:0]   own_mask;
  logic               rd_acc;
  logic [RD_LATENCY-1:0] rdv_q, rdv_d;
  logic [IDX_W-1:0]   rdo_q [RD_LATENCY];
  logic [IDX_W-1:0]   rdo_d [RD_LATENCY];

  // First requester after the last owner, wrapping around.
  always_comb begin
    pick       = last_q;
    pick_found = 1'b0;
    cand       = last_q;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % N_REQ);
      if (!pick_found && req_i[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = OWN;
          owner_d       = pick;
          last_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      OWN: begin
        if (!req_i[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    own_mask   = '0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    rd_acc     = 1'b0;
    if (state_q == OWN) begin
      own_mask[owner_q] = 1'b1;
      ram_we_o   = req_we_i[owner_q];
      ram_addr_o = req_addr_i[int'(owner_q)*AW +: AW];
      ram_data_o = req_data_i[int'(owner_q)*DW +: DW];
      rd_acc     = req_rd_i[owner_q];
    end
    err_d = err_q | (|((req_we_i | req_rd_i) & ~own_mask));
  end

  // Read tracker: stage 0 captures the accepted read, the last stage is delivered.
  always_comb begin
    rdv_d[0] = rd_acc;
    rdo_d[0] = owner_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rdv_d[i] = rdv_q[i-1];
      rdo_d[i] = rdo_q[i-1];
    end
    rd_valid_o = '0;
    if (rdv_q[RD_LATENCY-1]) rd_valid_o[rdo_q[RD_LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      err_q   <= 1'b0;
      rdv_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rdo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      rdv_q   <= rdv_d;
      for (int i = 0; i < RD_LATENCY; i++) rdo_q[i] <= rdo_d[i];
    end
  end

  assign grant_o   = grant_q;
  assign err_o     = err_q;
  assign rd_data_o = ram_data_i;

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant_q));

endmodule
